// File: rtl/mvau_inp_pingpong_buffer.sv
// rtl/mvau_inp_pingpong_buffer.sv - double-banked input vector buffer that replays each vector NF times
module mvau_inp_pingpong_buffer #(
  parameter int TI       = 8,
  parameter int SF       = 4,
  parameter int NF       = 3,
  parameter int BUF_ADDR = (SF > 1) ? $clog2(SF) : 1,
  parameter int NF_W     = (NF > 1) ? $clog2(NF) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_v,
  input  logic [TI-1:0] in,
  output logic          in_rdy,
  output logic          out_v,
  output logic [TI-1:0] out,
  input  logic          out_rdy,
  output logic          out_last,
  output logic [1:0]    bank_full
);

  localparam logic [BUF_ADDR-1:0] ADDR_LAST = BUF_ADDR'(SF - 1);
  localparam logic [NF_W-1:0]     FOLD_LAST = NF_W'(NF - 1);

  // Two banks of SF words; contents are never reset, only the full flags qualify them
  logic [TI-1:0]       mem_q [2][SF];

  logic                rdy_en_q,    rdy_en_d;
  logic                wr_bank_q,   wr_bank_d;
  logic [BUF_ADDR-1:0] wr_addr_q,   wr_addr_d;
  logic                rd_bank_q,   rd_bank_d;
  logic [BUF_ADDR-1:0] rd_addr_q,   rd_addr_d;
  logic [NF_W-1:0]     fold_q,      fold_d;
  logic [1:0]          bank_full_q, bank_full_d;
  logic                out_v_q,     out_v_d;
  logic [TI-1:0]       out_q,       out_d;
  logic                out_last_q,  out_last_d;

  logic wr_fire;
  logic rd_load;
  logic rd_final;

  assign in_rdy    = rdy_en_q && !bank_full_q[wr_bank_q];
  assign out_v     = out_v_q;
  assign out       = out_q;
  assign out_last  = out_last_q;
  assign bank_full = bank_full_q;

  // Next-state for write pointer, replay pointer and the output register stage
  always_comb begin
    rdy_en_d    = 1'b1;
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    rd_bank_d   = rd_bank_q;
    rd_addr_d   = rd_addr_q;
    fold_d      = fold_q;
    bank_full_d = bank_full_q;
    out_v_d     = out_v_q;
    out_d       = out_q;
    out_last_d  = out_last_q;

    wr_fire  = in_v && in_rdy;
    rd_load  = bank_full_q[rd_bank_q] && (!out_v_q || out_rdy);
    rd_final = (rd_addr_q == ADDR_LAST) && (fold_q == FOLD_LAST);

    // The writer only touches an empty bank and the reader only a full one,
    // so the set and clear below never target the same bank.
    if (wr_fire) begin
      if (wr_addr_q == ADDR_LAST) begin
        wr_addr_d              = '0;
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
      end else begin
        wr_addr_d = wr_addr_q + BUF_ADDR'(1);
      end
    end

    if (rd_load) begin
      out_d      = mem_q[rd_bank_q][rd_addr_q];
      out_v_d    = 1'b1;
      out_last_d = rd_final;
      if (rd_addr_q == ADDR_LAST) begin
        rd_addr_d = '0;
        if (fold_q == FOLD_LAST) begin
          fold_d                 = '0;
          bank_full_d[rd_bank_q] = 1'b0;
          rd_bank_d              = ~rd_bank_q;
        end else begin
          fold_d = fold_q + NF_W'(1);
        end
      end else begin
        rd_addr_d = rd_addr_q + BUF_ADDR'(1);
      end
    end else if (out_v_q && out_rdy) begin
      out_v_d = 1'b0;
    end
  end

  // Bank storage write
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_bank_q][wr_addr_q] <= in;
    end
  end

  // Control and output registers; reset discards any partial vector and pending replays
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q    <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      fold_q      <= '0;
      bank_full_q <= 2'b00;
      out_v_q     <= 1'b0;
      out_q       <= '0;
      out_last_q  <= 1'b0;
    end else begin
      rdy_en_q    <= rdy_en_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      rd_bank_q   <= rd_bank_d;
      rd_addr_q   <= rd_addr_d;
      fold_q      <= fold_d;
      bank_full_q <= bank_full_d;
      out_v_q     <= out_v_d;
      out_q       <= out_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_mvau_inp_pingpong_buffer.sv
// tb/tb_mvau_inp_pingpong_buffer.sv - directed checks of the ping-pong input buffer
module tb_mvau_inp_pingpong_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_v;
  logic [7:0] in_d;
  logic       out_rdy;

  logic       in_rdy0, out_v0, out_last0;
  logic [7:0] out0;
  logic [1:0] bank_full0;
  logic       in_rdy1, out_v1, out_last1;
  logic [7:0] out1;
  logic [1:0] bank_full1;

  always #5 clk = ~clk;

  mvau_inp_pingpong_buffer #(.TI(8), .SF(4), .NF(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_v(in_v), .in(in_d), .in_rdy(in_rdy0),
    .out_v(out_v0), .out(out0), .out_rdy(out_rdy), .out_last(out_last0),
    .bank_full(bank_full0)
  );

  mvau_inp_pingpong_buffer #(.TI(8), .SF(1), .NF(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_v(in_v), .in(in_d), .in_rdy(in_rdy1),
    .out_v(out_v1), .out(out1), .out_rdy(out_rdy), .out_last(out_last1),
    .bank_full(bank_full1)
  );

  // Observed instance select
  logic       sel1;
  logic       m_in_rdy, m_out_v, m_out_last;
  logic [7:0] m_out;
  logic [1:0] m_bf;
  always_comb begin
    m_in_rdy   = sel1 ? in_rdy1    : in_rdy0;
    m_out_v    = sel1 ? out_v1     : out_v0;
    m_out      = sel1 ? out1       : out0;
    m_out_last = sel1 ? out_last1  : out_last0;
    m_bf       = sel1 ? bank_full1 : bank_full0;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_in_rdy;
    logic       e_out_v;
    logic [7:0] e_out;
    logic       e_last;
    logic [1:0] e_bf;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy,
                              input logic ir, input logic ov, input logic [7:0] o,
                              input logic l, input logic [1:0] bf);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_in_rdy = ir; v.e_out_v = ov; v.e_out = o; v.e_last = l; v.e_bf = bf;
    return v;
  endfunction

  vec_t tbl [18];

  // Stream bookkeeping
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       rx_last_q[$];
  int         rx_cyc_q[$];
  int         acc_cyc_q[$];
  logic [7:0] exp_q[$];
  logic       exp_last_q[$];
  int         cyc_n, stall_cnt, hold_cnt, hold_err, first_last_cyc;
  logic       acc, prev_hold, prev_last;
  logic [7:0] prev_out;

  task automatic clear();
    tx_q.delete(); rx_q.delete(); rx_last_q.delete(); rx_cyc_q.delete();
    acc_cyc_q.delete(); exp_q.delete(); exp_last_q.delete();
    cyc_n = 0; stall_cnt = 0; hold_cnt = 0; hold_err = 0; first_last_cyc = -1;
    prev_hold = 1'b0; prev_last = 1'b0; prev_out = 8'h00; acc = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_v = 1'b0; out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: drive at negedge, record the transfers the next posedge will perform
  task automatic tick(input logic iv, input logic [7:0] id, input logic ordy);
    @(negedge clk);
    if (prev_hold) begin
      hold_cnt++;
      if (!m_out_v || m_out !== prev_out || m_out_last !== prev_last) hold_err++;
    end
    in_v = iv; in_d = id; out_rdy = ordy;
    #1;
    acc = iv && m_in_rdy;
    if (acc) acc_cyc_q.push_back(cyc_n);
    if (iv && !m_in_rdy) stall_cnt++;
    if (m_out_v && ordy) begin
      rx_q.push_back(m_out); rx_last_q.push_back(m_out_last); rx_cyc_q.push_back(cyc_n);
    end
    if (m_out_v && m_out_last && first_last_cyc < 0) first_last_cyc = cyc_n;
    prev_hold = m_out_v && !ordy;
    prev_out  = m_out;
    prev_last = m_out_last;
    cyc_n++;
  endtask

  // mode 0: out_rdy=1, mode 1: out_rdy toggles 1010, mode 2: out_rdy=0
  task automatic run(input int n_exp, input int max_cyc, input int mode, input string tag);
    logic ordy;
    logic iv;
    for (int k = 0; k < max_cyc && (n_exp == 0 || rx_q.size() < n_exp); k++) begin
      case (mode)
        0:       ordy = 1'b1;
        1:       ordy = (k % 2 == 0);
        default: ordy = 1'b0;
      endcase
      iv = (tx_q.size() > 0);
      tick(iv, iv ? tx_q[0] : 8'h00, ordy);
      if (acc) void'(tx_q.pop_front());
    end
    if (n_exp > 0) check({tag, "_rx_count"}, rx_q.size(), n_exp);
  endtask

  task automatic add_rep(input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input logic [7:0] w3);
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(w0); exp_last_q.push_back(1'b0);
      exp_q.push_back(w1); exp_last_q.push_back(1'b0);
      exp_q.push_back(w2); exp_last_q.push_back(1'b0);
      exp_q.push_back(w3); exp_last_q.push_back(f == 2);
    end
  endtask

  task automatic cmp_stream(input string tag);
    int we = 0;
    int le = 0;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      if (rx_q[i] !== exp_q[i]) we++;
      if (rx_last_q[i] !== exp_last_q[i]) le++;
    end
    check({tag, "_words_err"}, we, 0);
    check({tag, "_last_err"}, le, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] wv [4];
    wv[0] = 8'h11; wv[1] = 8'h22; wv[2] = 8'h33; wv[3] = 8'h44;

    // Basic replay table: row checked at negedge, then its inputs drive the next edge
    for (int i = 0; i < 4; i++) tbl[i] = mk(1'b1, wv[i], 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00);
    tbl[4] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'b01);
    for (int k = 0; k < 12; k++)
      tbl[5+k] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, wv[k%4], (k == 11), (k == 11) ? 2'b00 : 2'b01);
    tbl[17] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00);

    sel1 = 1'b0; rst_n = 1'b0; in_v = 1'b0; in_d = 8'h00; out_rdy = 1'b0;
    clear();
    repeat (3) @(negedge clk);
    check("rst_in_rdy", in_rdy0, 1'b0);
    check("rst_out_v", out_v0, 1'b0);
    check("rst_out", out0, 8'h00);
    check("rst_out_last", out_last0, 1'b0);
    check("rst_bank_full", bank_full0, 2'b00);
    check("rst1_in_rdy", in_rdy1, 1'b0);
    check("rst1_bank_full", bank_full1, 2'b00);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check($sformatf("tbl%0d_in_rdy", i), in_rdy0, tbl[i].e_in_rdy);
      check($sformatf("tbl%0d_out_v", i), out_v0, tbl[i].e_out_v);
      check($sformatf("tbl%0d_bank_full", i), bank_full0, tbl[i].e_bf);
      if (tbl[i].e_out_v) begin
        check($sformatf("tbl%0d_out", i), out0, tbl[i].e_out);
        check($sformatf("tbl%0d_out_last", i), out_last0, tbl[i].e_last);
      end
      in_v = tbl[i].iv; in_d = tbl[i].id; out_rdy = tbl[i].ordy;
    end

    // Overlap: B streams in during A's replay and follows A with no bubble
    do_reset(); clear();
    for (int i = 1; i <= 8; i++) tx_q.push_back(8'(i));
    add_rep(8'h01, 8'h02, 8'h03, 8'h04);
    add_rep(8'h05, 8'h06, 8'h07, 8'h08);
    run(24, 80, 0, "ovl");
    cmp_stream("ovl");
    check("ovl_in_stalls", stall_cnt, 0);
    if (rx_cyc_q.size() == 24 && acc_cyc_q.size() == 8) begin
      check("ovl_no_bubble", rx_cyc_q[23] - rx_cyc_q[0], 23);
      check("ovl_b_before_a_end", acc_cyc_q[7] < rx_cyc_q[11], 1'b1);
    end

    // Backpressure: three vectors, out_rdy held low until both banks fill
    do_reset(); clear();
    for (int i = 0; i < 12; i++) tx_q.push_back(8'h31 + 8'(i));
    add_rep(8'h31, 8'h32, 8'h33, 8'h34);
    add_rep(8'h35, 8'h36, 8'h37, 8'h38);
    add_rep(8'h39, 8'h3a, 8'h3b, 8'h3c);
    run(0, 12, 2, "bp_fill");
    check("bp_pending", tx_q.size(), 4);
    check("bp_full", m_bf, 2'b11);
    check("bp_in_rdy", m_in_rdy, 1'b0);
    check("bp_nothing_taken", rx_q.size(), 0);
    run(36, 200, 1, "bp");
    cmp_stream("bp");
    check("bp_hold_err", hold_err, 0);
    check("bp_hold_seen", hold_cnt > 0, 1'b1);
    if (acc_cyc_q.size() > 8)
      check("bp_c_accept_at_free", acc_cyc_q[8], first_last_cyc);
    else
      check("bp_c_accepted", acc_cyc_q.size(), 12);

    // SF=1, NF=1: output register takes A0, then both banks hold A1, A2
    do_reset(); clear();
    sel1 = 1'b1;
    tx_q.push_back(8'hA0); tx_q.push_back(8'hA1); tx_q.push_back(8'hA2);
    run(0, 6, 2, "deg_fill");
    check("deg_accepts", acc_cyc_q.size(), 3);
    check("deg_in_rdy", m_in_rdy, 1'b0);
    check("deg_full", m_bf, 2'b11);
    check("deg_out_v", m_out_v, 1'b1);
    check("deg_out_hold", m_out, 8'hA0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'hA0 + 8'(i)); exp_last_q.push_back(1'b1);
    end
    run(3, 20, 0, "deg");
    cmp_stream("deg");
    sel1 = 1'b0;

    // Reset mid-replay drops out_v asynchronously
    do_reset(); clear();
    for (int i = 0; i < 4; i++) tx_q.push_back(8'h91 + 8'(i));
    run(5, 40, 0, "mid");
    @(posedge clk); #2;
    check("mid_out_v_before", out_v0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_out_v_async", out_v0, 1'b0);
    check("mid_bank_full", bank_full0, 2'b00);
    check("mid_in_rdy", in_rdy0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear();
    tx_q.push_back(8'h55); tx_q.push_back(8'h66); tx_q.push_back(8'h77); tx_q.push_back(8'h88);
    add_rep(8'h55, 8'h66, 8'h77, 8'h88);
    run(12, 60, 0, "mid_new");
    cmp_stream("mid_new");

    // Partial vector discarded by reset
    do_reset(); clear();
    tx_q.push_back(8'hC1); tx_q.push_back(8'hC2);
    run(0, 8, 0, "part");
    check("part_accepts", acc_cyc_q.size(), 2);
    check("part_no_out", rx_q.size(), 0);
    check("part_out_v", m_out_v, 1'b0);
    do_reset(); clear();
    for (int i = 0; i < 4; i++) tx_q.push_back(8'hD1 + 8'(i));
    add_rep(8'hD1, 8'hD2, 8'hD3, 8'hD4);
    run(12, 60, 0, "part_new");
    cmp_stream("part_new");
    run(0, 6, 0, "part_idle");
    check("part_no_extra", rx_q.size(), 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
